inst_queue: RTL and testbench
=============================

// Module: inst_queue
// PURPOSE
//   Instruction queue between the fetch stage and the decode stage.
//   - Buffers fetched {pc, inst, adef} entries so fetch keeps running while decode stalls.
//   - Presents the head entry, first-word-fall-through, to the decode stage's field decoders.
//   - Flushed on branch-taken or exception redirect.
// PARAMETERS
//   DEPTH   4   number of entries; power of two, >= 2
//   AW      2   log2(DEPTH); pointer index width
// PORTS
//   clk        in   1      core clock; all state updates on rising edge
//   reset      in   1      asynchronous, active-high; clears all state immediately
//   flush      in   1      synchronous redirect flush from EXE/WB
//   in_valid   in   1      fetch offers an entry
//   in_ready   out  1      queue accepts an entry this cycle
//   in_pc      in   32     PC of offered instruction
//   in_inst    in   32     instruction word
//   in_adef    in   1      fetch address-error flag travelling with entry
//   out_valid  out  1      head entry valid toward decode
//   out_ready  in   1      decode consumes head this cycle (ds_allowin)
//   out_pc     out  32     head PC
//   out_inst   out  32     head instruction
//   out_adef   out  1      head address-error flag
//   count      out  AW+1   current occupancy, 0..DEPTH
// BEHAVIOUR
//   - Reset: rd_ptr=wr_ptr=0, count=0, storage cleared to 0.
//     Outputs: out_valid=0, out_pc=0, out_inst=0, out_adef=0, in_ready=1.
//   - Pointers are AW+1 bits (wrap bit).
//     - empty = (rd_ptr==wr_ptr).
//     - full = index bits equal and wrap bits differ.
//   - Handshake rules:
//     - in_ready  = !full && !flush.
//     - out_valid = !empty && !flush.
//     - push = in_valid && in_ready; pop = out_valid && out_ready.
//   - Push: store {in_pc,in_inst,in_adef} at wr_ptr[AW-1:0], then wr_ptr+1 (mod 2^(AW+1)).
//   - Pop: rd_ptr+1.
//   - out_* combinationally read entry rd_ptr[AW-1:0]; no output register.
//   - Latency: an entry pushed at edge N is on out_* with out_valid=1 in cycle N+1.
//     - No same-cycle bypass when empty.
//   - Simultaneous push and pop (non-full, non-empty): both occur; count unchanged.
//   - Full: in_ready=0 even if a pop happens that cycle (no full-bypass).
//     - Accept resumes the cycle after the pop.
//   - Empty: out_valid=0; out_* show stale data, which decode must ignore.
//   - Flush has priority over push and pop.
//     - Next edge: rd_ptr=wr_ptr=0, count=0.
//     - Storage is not cleared; in_adef of the offered entry is dropped.
//   - Async reset asserted mid-operation: all pointers and count go to 0 at once.
//     - Queued entries are lost.
//     - On deassert, the first accept is possible in the next cycle.
//   - count = wr_ptr - rd_ptr, in AW+1 bits.
// STRUCTURE
//   - Shared header mycpu_defs.vh holds:
//     - `IQ_ENTRY_WD` (65) = {adef, pc, inst}.
//     - `IQ_DEPTH` default.
//   - Storage: DEPTH x `IQ_ENTRY_WD` regs.
//     - Write enable is a one-hot decode of wr_ptr index gated by push.
//   - One sub-module, iq_ptr: an AW+1-bit pointer with inc and clr inputs and async reset.
//     - Instantiated twice (rd, wr).
// TESTING
//   - Reset then idle -> out_valid=0, in_ready=1, count=0.
//   - Push pc=0x1c000000 inst=0x02800c0c, out_ready=0 -> next cycle out_valid=1, out_pc=0x1c000000, count=1.
//   - Push 4 entries with out_ready=0 -> in_ready=0, count=4.
//     - Then hold out_ready=1 -> pops in order 0x..00,04,08,0c; in_ready=1 after first pop.
//   - count=2, push+pop same cycle -> count stays 2; FIFO order preserved across index wrap.
//   - count=3 with in_valid=1, out_ready=1, flush=1 -> nothing consumed; next cycle count=0, out_valid=0.
//   - Async reset pulsed between edges with count=2 -> out_valid=0 and count=0 before next edge.

Source files
------------

// File: rtl/inst_queue_pkg.sv
// Shared definitions for the fetch-to-decode instruction queue.
package inst_queue_pkg;

    // Width of one queued entry: {adef, pc, inst}
    localparam int unsigned IQ_ENTRY_WD = 65;
    // Default queue depth
    localparam int unsigned IQ_DEPTH    = 4;

    typedef struct packed {
        logic        adef;
        logic [31:0] pc;
        logic [31:0] inst;
    } iq_entry_t;

endpackage

// File: rtl/inst_queue_iq_ptr.sv
// Queue pointer with a wrap bit; increments on inc, returns to zero on clr.
module iq_ptr #(
    parameter int unsigned AW = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          inc,
    input  logic          clr,
    output logic [AW:0]   ptr
);

    logic [AW:0] ptr_q;
    logic [AW:0] ptr_d;

    // Next pointer value: clear wins over increment
    always_comb begin
        ptr_d = ptr_q;
        if (clr) begin
            ptr_d = '0;
        end else if (inc) begin
            ptr_d = ptr_q + (AW+1)'(1);
        end
    end

    // Pointer register with asynchronous reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr = ptr_q;

endmodule

// File: rtl/inst_queue.sv
// Instruction queue between fetch and decode: first-word-fall-through FIFO
// of {pc, inst, adef} entries, flushed on redirect.
module inst_queue
    import inst_queue_pkg::*;
#(
    parameter int unsigned DEPTH = IQ_DEPTH,
    parameter int unsigned AW    = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          flush,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [31:0]   in_pc,
    input  logic [31:0]   in_inst,
    input  logic          in_adef,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [31:0]   out_pc,
    output logic [31:0]   out_inst,
    output logic          out_adef,
    output logic [AW:0]   count
);

    logic [AW:0]      rd_ptr;
    logic [AW:0]      wr_ptr;
    logic             empty;
    logic             full;
    logic             push;
    logic             pop;
    logic [DEPTH-1:0] we;
    iq_entry_t        in_entry;
    iq_entry_t        head;
    iq_entry_t        mem_q [DEPTH];
    iq_entry_t        mem_d [DEPTH];

    assign empty = (rd_ptr == wr_ptr);
    assign full  = (rd_ptr[AW-1:0] == wr_ptr[AW-1:0]) && (rd_ptr[AW] != wr_ptr[AW]);

    // Flush masks both handshakes, so it overrides push and pop.
    // Full blocks accept even when a pop happens in the same cycle.
    assign in_ready  = !full && !flush;
    assign out_valid = !empty && !flush;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    assign in_entry = '{adef: in_adef, pc: in_pc, inst: in_inst};

    iq_ptr #(.AW(AW)) u_rd_ptr (
        .clk   (clk),
        .reset (reset),
        .inc   (pop),
        .clr   (flush),
        .ptr   (rd_ptr)
    );

    iq_ptr #(.AW(AW)) u_wr_ptr (
        .clk   (clk),
        .reset (reset),
        .inc   (push),
        .clr   (flush),
        .ptr   (wr_ptr)
    );

    // One-hot write enable from the write index, gated by push
    always_comb begin
        we = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (push && (wr_ptr[AW-1:0] == AW'(i))) begin
                we[i] = 1'b1;
            end
        end
    end

    // Next storage contents: only the enabled slot takes the offered entry
    always_comb begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
            mem_d[i] = we[i] ? in_entry : mem_q[i];
        end
    end

    // Entry storage, cleared on reset; flush leaves contents untouched
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    assign head     = mem_q[rd_ptr[AW-1:0]];
    assign out_pc   = head.pc;
    assign out_inst = head.inst;
    assign out_adef = head.adef;
    assign count    = wr_ptr - rd_ptr;

endmodule

// File: tb/tb_inst_queue.sv
// Scoreboard bench for inst_queue: the driver queues expected entries on
// accept, a negedge monitor pops and compares whenever decode consumes.
module tb_inst_queue;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned AW    = 2;

    logic          clk;
    logic          reset;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [31:0]   in_pc;
    logic [31:0]   in_inst;
    logic          in_adef;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   out_pc;
    logic [31:0]   out_inst;
    logic          out_adef;
    logic [AW:0]   count;

    int checks = 0;
    int errors = 0;
    int mcount = 0;
    logic [64:0] sb [$];

    inst_queue #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pc     (in_pc),
        .in_inst   (in_inst),
        .in_adef   (in_adef),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pc    (out_pc),
        .out_inst  (out_inst),
        .out_adef  (out_adef),
        .count     (count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: act=timeout req=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [64:0] act, input logic [64:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: act=%h req=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: each consumed head must match the oldest accepted entry
    initial begin
        forever begin
            @(negedge clk);
            if (!reset && out_valid === 1'b1 && out_ready === 1'b1) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL pop_unexpected: act=%h req=none", {out_adef, out_pc, out_inst});
                end else begin
                    chk("pop_data", {out_adef, out_pc, out_inst}, sb.pop_front());
                end
            end
        end
    end

    // One cycle of stimulus: drive, check handshake/count at negedge, update model
    task automatic step(input logic v, input logic [31:0] pc, input logic [31:0] inst,
                        input logic adef, input logic ordy, input logic fl);
        logic acc;
        logic pp;
        in_valid  = v;
        in_pc     = pc;
        in_inst   = inst;
        in_adef   = adef;
        out_ready = ordy;
        flush     = fl;
        acc = v && (mcount < DEPTH) && !fl;
        pp  = (mcount > 0) && ordy && !fl;
        if (acc) sb.push_back({adef, pc, inst});
        @(negedge clk);
        chk("in_ready",  65'(in_ready),  65'((mcount < DEPTH) && !fl));
        chk("out_valid", 65'(out_valid), 65'((mcount > 0) && !fl));
        chk("count",     65'(count),     65'(mcount));
        @(posedge clk);
        #1;
        if (fl) begin
            mcount = 0;
            sb.delete();
        end else begin
            mcount = mcount + (acc ? 1 : 0) - (pp ? 1 : 0);
        end
    endtask

    task automatic idle(input logic ordy);
        step(1'b0, 32'h0, 32'h0, 1'b0, ordy, 1'b0);
    endtask

    initial begin
        reset = 1'b1;
        flush = 1'b0;
        in_valid = 1'b0;
        in_pc = '0;
        in_inst = '0;
        in_adef = 1'b0;
        out_ready = 1'b0;
        #2;
        chk("rst_out_valid", 65'(out_valid), 65'(0));
        chk("rst_in_ready",  65'(in_ready),  65'(1));
        chk("rst_count",     65'(count),     65'(0));
        chk("rst_out_data",  {out_adef, out_pc, out_inst}, 65'(0));
        @(posedge clk);
        #1;
        reset = 1'b0;
        idle(1'b0);

        // Single entry: visible the cycle after the push edge
        step(1'b1, 32'h1c000000, 32'h02800c0c, 1'b0, 1'b0, 1'b0);
        idle(1'b0);
        chk("first_out_pc", 65'(out_pc), 65'(32'h1c000000));
        idle(1'b1);

        // Fill to full, attempt push while full and while popping
        for (int k = 0; k < 4; k++)
            step(1'b1, 32'h1c000100 + 32'(4*k), 32'hab000000 + 32'(k), 1'(k & 1), 1'b0, 1'b0);
        step(1'b1, 32'h1c0001f0, 32'hdeadbeef, 1'b1, 1'b0, 1'b0);
        step(1'b1, 32'h1c0001f4, 32'hdeadbee0, 1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) idle(1'b1);
        idle(1'b1);

        // Steady push+pop at count=2 across index wrap
        step(1'b1, 32'h1c000200, 32'h11111111, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h1c000204, 32'h22222222, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 6; k++)
            step(1'b1, 32'h1c000208 + 32'(4*k), 32'h33330000 + 32'(k), 1'(k % 3 == 0), 1'b1, 1'b0);
        idle(1'b1);
        idle(1'b1);
        idle(1'b1);

        // Flush overrides push and pop at count=3
        for (int k = 0; k < 3; k++)
            step(1'b1, 32'h1c000300 + 32'(4*k), 32'h44440000 + 32'(k), 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h1c00030c, 32'h55555555, 1'b1, 1'b1, 1'b1);
        idle(1'b1);

        // Async reset between edges with count=2
        step(1'b1, 32'h1c000400, 32'h66666666, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h1c000404, 32'h77777777, 1'b0, 1'b0, 1'b0);
        chk("pre_rst_count", 65'(count), 65'(2));
        #1 reset = 1'b1;
        #1;
        chk("async_out_valid", 65'(out_valid), 65'(0));
        chk("async_count",     65'(count),     65'(0));
        reset = 1'b0;
        mcount = 0;
        sb.delete();
        step(1'b1, 32'h1c000500, 32'h88888888, 1'b1, 1'b0, 1'b0);
        idle(1'b1);
        idle(1'b0);

        chk("sb_drained", 65'(sb.size()), 65'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
